// File: rtl/hes_pkg.sv
// hes_pkg: shared types and the keystream substitution table for the
// HES stream arbiter and its keystream unit.
package hes_pkg;

    // Arbiter FSM: IDLE picks the next requester, STREAM moves its bytes.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // 16x16 substitution table, indexed [high nibble][low nibble].
    localparam logic [7:0] SBOX [16][16] = '{
        '{8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb},
        '{8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb},
        '{8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e},
        '{8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25},
        '{8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92},
        '{8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84},
        '{8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06},
        '{8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b},
        '{8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73},
        '{8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e},
        '{8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b},
        '{8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4},
        '{8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f},
        '{8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef},
        '{8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61},
        '{8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d}
    };

    // Table lookup: high nibble selects the row, low nibble the column.
    function automatic logic [7:0] sbox_lookup(input logic [7:0] addr);
        return SBOX[addr[7:4]][addr[3:0]];
    endfunction

endpackage

// File: rtl/hes_keystream_unit.sv
// hes_keystream_unit: combinational keystream byte generation.
// result = data ^ SBOX[(key + idx) mod 256]; the 8-bit add wraps naturally.
module hes_keystream_unit
    import hes_pkg::*;
(
    input  logic [7:0] key,
    input  logic [7:0] idx,
    input  logic [7:0] data,
    output logic [7:0] result
);

    logic [7:0] sbox_addr;

    assign sbox_addr = key + idx;
    assign result    = data ^ sbox_lookup(sbox_addr);

endmodule

// File: rtl/hes_stream_arbiter.sv
// hes_stream_arbiter: round-robin arbiter sharing one keystream unit among
// NUM_CH byte-stream requesters. Each channel keeps its own key/index context
// so a message cut short by the burst limit resumes where it left off.
module hes_stream_arbiter
    import hes_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int MAX_BURST = 16
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*8-1:0]       cfg_key,
    input  logic [NUM_CH-1:0]         req_valid,
    input  logic [NUM_CH-1:0]         req_first,
    input  logic [NUM_CH-1:0]         req_last,
    input  logic [NUM_CH*8-1:0]       req_data,
    output logic [NUM_CH-1:0]         req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_last,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] grant_ch
);

    localparam int              CH_W        = $clog2(NUM_CH);
    localparam logic [7:0]      BURST_LIMIT = 8'(MAX_BURST);
    localparam logic [CH_W-1:0] LAST_CH     = CH_W'(NUM_CH - 1);

    state_t          state;
    state_t          state_next;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] rr_after;
    logic [CH_W-1:0] pick_ch;
    logic            pick_found;
    logic [7:0]      burst_cnt;
    logic [7:0]      burst_next;

    logic [7:0]      key_ctx     [NUM_CH];
    logic [7:0]      idx_ctx     [NUM_CH];
    logic [7:0]      cfg_key_ch  [NUM_CH];
    logic [7:0]      req_data_ch [NUM_CH];

    logic            out_slot_free;
    logic            sel_valid;
    logic            sel_first;
    logic            sel_last;
    logic [7:0]      sel_data;
    logic [7:0]      use_key;
    logic [7:0]      use_idx;
    logic [7:0]      ks_result;
    logic            accept;
    logic            release_last;
    logic            release_burst;
    logic            release_any;

    // Split the flat per-channel buses into byte arrays for easy indexing.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign cfg_key_ch[g]  = cfg_key[g*8 +: 8];
        assign req_data_ch[g] = req_data[g*8 +: 8];
    end

    assign out_slot_free = !out_valid || out_ready;
    assign sel_valid     = req_valid[grant_ch];
    assign sel_first     = req_first[grant_ch];
    assign sel_last      = req_last[grant_ch];
    assign sel_data      = req_data_ch[grant_ch];
    assign accept        = (state == STREAM) && sel_valid && out_slot_free;

    // A first byte restarts the message from the live key and index zero.
    assign use_key = sel_first ? cfg_key_ch[grant_ch] : key_ctx[grant_ch];
    assign use_idx = sel_first ? 8'h00 : idx_ctx[grant_ch];

    assign burst_next    = burst_cnt + 8'd1;
    assign release_last  = accept && sel_last;
    assign release_burst = accept && (burst_next == BURST_LIMIT);
    assign release_any   = release_last || release_burst;
    assign rr_after      = (grant_ch == LAST_CH) ? '0 : grant_ch + CH_W'(1);
    assign busy          = (state == STREAM);

    hes_keystream_unit u_keystream (
        .key    (use_key),
        .idx    (use_idx),
        .data   (sel_data),
        .result (ks_result)
    );

    // Round-robin pick: first requester at or above rr_ptr, else wrap to the lowest.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!pick_found && req_valid[c] && (CH_W'(c) >= rr_ptr)) begin
                pick_found = 1'b1;
                pick_ch    = CH_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!pick_found && req_valid[c] && (CH_W'(c) < rr_ptr)) begin
                pick_found = 1'b1;
                pick_ch    = CH_W'(c);
            end
        end
    end

    // Next-state and ready generation; only the granted channel ever sees ready.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                req_ready[grant_ch] = out_slot_free;
                if (release_any) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, burst counting and round-robin pointer advance on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_ch  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            if (state == IDLE && pick_found) begin
                grant_ch  <= pick_ch;
                burst_cnt <= '0;
            end else if (accept) begin
                burst_cnt <= burst_next;
            end
            if (release_any) begin
                rr_ptr <= rr_after;
            end
        end
    end

    // Per-channel key/index context; a last byte rewinds the index for the next message.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                key_ctx[c] <= '0;
                idx_ctx[c] <= '0;
            end
        end else if (accept) begin
            if (sel_first) begin
                key_ctx[grant_ch] <= cfg_key_ch[grant_ch];
            end
            idx_ctx[grant_ch] <= sel_last ? 8'h00 : use_idx + 8'd1;
        end
    end

    // Output register with valid/ready; a new accept overwrites, otherwise drain on ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= ks_result;
            out_ch    <= grant_ch;
            out_last  <= sel_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hes_stream_arbiter.sv
// tb_hes_stream_arbiter: directed vectors with hand-computed results, a
// per-channel request driver and a scoreboard monitor on the output port.
module tb_hes_stream_arbiter;

    localparam int NUM_CH    = 4;
    localparam int MAX_BURST = 2;
    localparam int CH_W      = 2;
    localparam int DEPTH     = 32;

    typedef struct packed {
        logic [7:0] data;
        logic       is_first;
        logic       is_last;
    } stim_t;

    typedef struct packed {
        logic [7:0]      data;
        logic [CH_W-1:0] ch;
        logic            is_last;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_CH*8-1:0] cfg_key;
    logic [NUM_CH-1:0]   req_valid;
    logic [NUM_CH-1:0]   req_first;
    logic [NUM_CH-1:0]   req_last;
    logic [NUM_CH*8-1:0] req_data;
    logic [NUM_CH-1:0]   req_ready;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_data;
    logic [CH_W-1:0]     out_ch;
    logic                out_last;
    logic                busy;
    logic [CH_W-1:0]     grant_ch;

    stim_t stim_mem [NUM_CH][DEPTH];
    int    head [NUM_CH] = '{default: 0};
    int    tail [NUM_CH] = '{default: 0};
    exp_t  sb [$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    hes_stream_arbiter #(
        .NUM_CH    (NUM_CH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_key   (cfg_key),
        .req_valid (req_valid),
        .req_first (req_first),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .busy      (busy),
        .grant_ch  (grant_ch)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic applyStimulus(input int ch, input logic [7:0] data, input logic is_first, input logic is_last);
        stim_mem[ch][tail[ch]] = '{data: data, is_first: is_first, is_last: is_last};
        tail[ch]++;
    endtask

    task automatic expectOut(input logic [7:0] data, input int ch, input logic is_last);
        sb.push_back('{data: data, ch: CH_W'(ch), is_last: is_last});
    endtask

    function automatic bit drained();
        for (int c = 0; c < NUM_CH; c++) begin
            if (head[c] != tail[c]) return 1'b0;
        end
        return (sb.size() == 0) && !out_valid && !busy;
    endfunction

    task automatic waitIdle(input string name, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (drained()) break;
        end
        if (n == budget) timeoutFail(name);
    endtask

    // Driver: presents each channel's queued byte and advances after a handshake.
    initial begin : driver
        logic [NUM_CH-1:0] acc;
        req_valid = '0;
        req_first = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc[c] && head[c] < tail[c]) head[c]++;
                if (head[c] < tail[c]) begin
                    req_valid[c]        = 1'b1;
                    req_first[c]        = stim_mem[c][head[c]].is_first;
                    req_last[c]         = stim_mem[c][head[c]].is_last;
                    req_data[c*8 +: 8]  = stim_mem[c][head[c]].data;
                end else begin
                    req_valid[c]        = 1'b0;
                    req_first[c]        = 1'b0;
                    req_last[c]         = 1'b0;
                    req_data[c*8 +: 8]  = 8'h00;
                end
            end
        end
    end

    // Monitor: every output handshake pops one scoreboard entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_output: got data 0x%0h ch %0d, expected none", out_data, out_ch);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_data", 32'(out_data), 32'(e.data));
                    checkOutput("out_ch",   32'(out_ch),   32'(e.ch));
                    checkOutput("out_last", 32'(out_last), 32'(e.is_last));
                end
            end
        end
    end

    initial begin : main
        int n;
        cfg_key   = '0;
        out_ready = 1'b1;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_data",  32'(out_data),  32'h0);
        checkOutput("rst_out_ch",    32'(out_ch),    32'h0);
        checkOutput("rst_out_last",  32'(out_last),  32'h0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_busy",      32'(busy),      32'h0);
        checkOutput("rst_grant_ch",  32'(grant_ch),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three-byte message on ch0, key 0x00 (burst limit splits it, same channel resumes).
        applyStimulus(0, 8'h00, 1'b1, 1'b0); expectOut(8'h52, 0, 1'b0);
        applyStimulus(0, 8'h00, 1'b0, 1'b0); expectOut(8'h09, 0, 1'b0);
        applyStimulus(0, 8'h00, 1'b0, 1'b1); expectOut(8'h6a, 0, 1'b1);
        waitIdle("single_channel", 60);

        // Key 0xFF: second byte's address wraps to 0x00.
        cfg_key[7:0] = 8'hff;
        applyStimulus(0, 8'h00, 1'b1, 1'b0); expectOut(8'h7d, 0, 1'b0);
        applyStimulus(0, 8'h00, 1'b0, 1'b1); expectOut(8'h52, 0, 1'b1);
        waitIdle("key_wrap", 60);

        // Single-byte message on ch3 brings rr_ptr back to 0.
        applyStimulus(3, 8'h00, 1'b1, 1'b1); expectOut(8'h52, 3, 1'b1);
        waitIdle("single_byte", 60);

        // ch1 and ch2 pending together with rr_ptr=0: ch1 first, then ch2.
        cfg_key[15:8]  = 8'h10;
        cfg_key[23:16] = 8'h10;
        applyStimulus(1, 8'h00, 1'b1, 1'b1); expectOut(8'h7c, 1, 1'b1);
        applyStimulus(2, 8'h00, 1'b1, 1'b1); expectOut(8'h7c, 2, 1'b1);
        waitIdle("round_robin", 60);

        // rr_ptr is now 3: with ch0 and ch3 pending, ch3 goes first.
        applyStimulus(0, 8'h00, 1'b1, 1'b1);
        applyStimulus(3, 8'h00, 1'b1, 1'b1);
        expectOut(8'h52, 3, 1'b1);
        expectOut(8'h7d, 0, 1'b1);
        waitIdle("rr_wrap", 60);

        // Burst limit: ch0 is cut after two bytes, ch1 is served, ch0 resumes at idx 2.
        cfg_key[7:0] = 8'h00;
        applyStimulus(0, 8'h00, 1'b1, 1'b0);
        applyStimulus(0, 8'h00, 1'b0, 1'b0);
        applyStimulus(0, 8'h00, 1'b0, 1'b1);
        expectOut(8'h52, 0, 1'b0);
        expectOut(8'h09, 0, 1'b0);
        expectOut(8'h7c, 1, 1'b1);
        expectOut(8'h6a, 0, 1'b1);
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy && grant_ch == 2'd0) break;
        end
        if (n == 40) timeoutFail("burst_grant");
        applyStimulus(1, 8'h00, 1'b1, 1'b1);
        waitIdle("burst_limit", 80);

        // Backpressure: the held output must not move and ready must stay low.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(0, 8'h00, 1'b1, 1'b0); expectOut(8'h52, 0, 1'b0);
        applyStimulus(0, 8'h00, 1'b0, 1'b1); expectOut(8'h09, 0, 1'b1);
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (n == 40) timeoutFail("bp_first_output");
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("bp_req_ready", 32'(req_ready[0]), 32'h0);
            checkOutput("bp_out_data",  32'(out_data),     32'h52);
            checkOutput("bp_out_valid", 32'(out_valid),    32'h1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitIdle("backpressure", 60);

        // Reset mid-message: contexts and output register are discarded.
        cfg_key[7:0] = 8'h10;
        applyStimulus(0, 8'h00, 1'b1, 1'b0); expectOut(8'h7c, 0, 1'b0);
        applyStimulus(0, 8'h00, 1'b0, 1'b0); expectOut(8'he3, 0, 1'b0);
        applyStimulus(0, 8'h00, 1'b0, 1'b0);
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (n == 40) timeoutFail("mid_msg_outputs");
        rst = 1'b1;
        for (int c = 0; c < NUM_CH; c++) head[c] = tail[c];
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("mid_rst_out_data",  32'(out_data),  32'h0);
        checkOutput("mid_rst_out_ch",    32'(out_ch),    32'h0);
        checkOutput("mid_rst_out_last",  32'(out_last),  32'h0);
        checkOutput("mid_rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("mid_rst_busy",      32'(busy),      32'h0);
        checkOutput("mid_rst_grant_ch",  32'(grant_ch),  32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Non-first byte after reset: idx 0 and key 0x00 despite a new cfg_key.
        cfg_key[7:0] = 8'h5a;
        applyStimulus(0, 8'h00, 1'b0, 1'b1); expectOut(8'h52, 0, 1'b1);
        waitIdle("post_reset", 60);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
